// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory req/ack handshake and
// feeds IF/ID, with a one-entry skid buffer for stalls and a redirect register for flushes.
module if_stage #(
    parameter int unsigned              PC_WIDTH   = 11,
    parameter int unsigned              INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]      RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0]    NOP        = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [PC_WIDTH-1:0]     branch_target,
    output logic                    mem_req,
    output logic [PC_WIDTH-1:0]     mem_addr,
    input  logic                    mem_ack,
    input  logic [INST_WIDTH-1:0]   mem_rdata,
    output logic [INST_WIDTH-1:0]   instruccion,
    output logic [PC_WIDTH-1:0]     pc_out,
    output logic                    valid
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e                  r_state, w_state_next;
    logic [PC_WIDTH-1:0]     r_pc, w_pc_next;
    logic [INST_WIDTH-1:0]   r_inst, w_inst_next;
    logic [PC_WIDTH-1:0]     r_pc_out, w_pc_out_next;
    logic                    r_valid, w_valid_next;
    logic [INST_WIDTH-1:0]   r_skid_inst, w_skid_inst_next;
    logic [PC_WIDTH-1:0]     r_skid_pc, w_skid_pc_next;
    logic [PC_WIDTH-1:0]     r_redirect, w_redirect_next;

    logic [PC_WIDTH-1:0]     w_pc_inc;
    logic [PC_WIDTH-1:0]     w_target;

    // Wraps modulo 2^PC_WIDTH by construction.
    assign w_pc_inc = r_pc + PC_WIDTH'(4);
    assign w_target = {branch_target[PC_WIDTH-1:2], 2'b00};

    // Request stays up in FETCH/DRAIN until acked; it is only ever dropped by HOLD or reset.
    assign mem_req     = reset_n && (r_state != StHold);
    assign mem_addr    = r_pc;
    assign instruccion = r_inst;
    assign pc_out      = r_pc_out;
    assign valid       = r_valid;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_inst_next      = r_inst;
        w_pc_out_next    = r_pc_out;
        w_valid_next     = r_valid;
        w_skid_inst_next = r_skid_inst;
        w_skid_pc_next   = r_skid_pc;
        w_redirect_next  = r_redirect;

        unique case (r_state)
            StFetch: begin
                if (branch_taken) begin
                    w_inst_next  = NOP;
                    w_valid_next = 1'b0;
                    if (mem_ack) begin
                        w_pc_next = w_target;
                    end else begin
                        w_redirect_next = w_target;
                        w_state_next    = StDrain;
                    end
                end else if (mem_ack) begin
                    w_pc_next = w_pc_inc;
                    if (stall) begin
                        w_skid_inst_next = mem_rdata;
                        w_skid_pc_next   = w_pc_inc;
                        w_state_next     = StHold;
                    end else begin
                        w_inst_next   = mem_rdata;
                        w_pc_out_next = w_pc_inc;
                        w_valid_next  = 1'b1;
                    end
                end else if (!stall) begin
                    w_inst_next  = NOP;
                    w_valid_next = 1'b0;
                end
            end
            StHold: begin
                if (branch_taken) begin
                    w_pc_next    = w_target;
                    w_inst_next  = NOP;
                    w_valid_next = 1'b0;
                    w_state_next = StFetch;
                end else if (!stall) begin
                    w_inst_next   = r_skid_inst;
                    w_pc_out_next = r_skid_pc;
                    w_valid_next  = 1'b1;
                    w_state_next  = StFetch;
                end
            end
            StDrain: begin
                w_inst_next  = NOP;
                w_valid_next = 1'b0;
                if (branch_taken) begin
                    w_redirect_next = w_target;
                end
                // The in-flight word belongs to the squashed path; only its ack matters.
                if (mem_ack) begin
                    w_pc_next    = branch_taken ? w_target : r_redirect;
                    w_state_next = StFetch;
                end
            end
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StFetch;
            r_pc        <= RESET_PC;
            r_inst      <= NOP;
            r_pc_out    <= '0;
            r_valid     <= 1'b0;
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
            r_redirect  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_inst      <= w_inst_next;
            r_pc_out    <= w_pc_out_next;
            r_valid     <= w_valid_next;
            r_skid_inst <= w_skid_inst_next;
            r_skid_pc   <= w_skid_pc_next;
            r_redirect  <= w_redirect_next;
        end
    end

endmodule
